// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU. A 2-entry FIFO feeds the register file.
// The flag register commits on push, and COND_TRUE evaluates branch conditions on it.
module alu_writeback (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] ALU_RESULT,
    input  logic [3:0]  FLAG_IN,
    input  logic [2:0]  RD_ADDR,
    input  logic        WE_REG,
    input  logic        WE_FLAG,
    input  logic [3:0]  COND,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] WB_DATA,
    output logic [2:0]  WB_ADDR,
    output logic        WB_WE,
    output logic [3:0]  FLAG_REG,
    output logic        COND_TRUE
);

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  addr;
        logic        we;
    } wb_entry_t;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,  C_EQ  = 4'd1,  C_NE  = 4'd2,  C_MI  = 4'd3,
        C_PL     = 4'd4,  C_CS  = 4'd5,  C_CC  = 4'd6,  C_VS  = 4'd7,
        C_VC     = 4'd8,  C_LT  = 4'd9,  C_GE  = 4'd10, C_GT  = 4'd11,
        C_LE     = 4'd12, C_HI  = 4'd13, C_LS  = 4'd14, C_NEVER = 4'd15
    } cond_e;

    wb_entry_t   r_mem [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [3:0]  r_flags;

    logic        w_push;
    logic        w_pop;
    wb_entry_t   w_head;
    logic        w_s, w_z, w_c, w_v;

    assign IN_READY  = (r_count != 2'd2);
    assign OUT_VALID = (r_count != 2'd0);
    assign w_push    = IN_VALID & IN_READY;
    assign w_pop     = OUT_VALID & OUT_READY;

    // The head slot's contents are masked while empty, so stale data never reaches WB_*.
    assign w_head  = OUT_VALID ? r_mem[r_rd_ptr] : '0;
    assign WB_DATA = w_head.data;
    assign WB_ADDR = w_head.addr;
    assign WB_WE   = OUT_VALID & w_head.we;

    // NOTE: storage is deliberately left unreset; r_count gates every read of it,
    // so clearing the count is enough to discard queued entries.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{data: ALU_RESULT, addr: RD_ADDR, we: WE_REG};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values and ordering between always_ff blocks cannot matter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_flags  <= 4'b0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && WE_FLAG) begin
                r_flags <= FLAG_IN;
            end
        end
    end

    assign FLAG_REG = r_flags;
    assign {w_s, w_z, w_c, w_v} = r_flags;

    // NOTE: COND_TRUE gets a default before the case so no path can infer a latch.
    // C is a borrow after subtraction: C=1 means A < B unsigned.
    always_comb begin
        COND_TRUE = 1'b0;
        case (cond_e'(COND))
            C_ALWAYS: COND_TRUE = 1'b1;
            C_EQ:     COND_TRUE = w_z;
            C_NE:     COND_TRUE = ~w_z;
            C_MI:     COND_TRUE = w_s;
            C_PL:     COND_TRUE = ~w_s;
            C_CS:     COND_TRUE = w_c;
            C_CC:     COND_TRUE = ~w_c;
            C_VS:     COND_TRUE = w_v;
            C_VC:     COND_TRUE = ~w_v;
            C_LT:     COND_TRUE = w_s ^ w_v;
            C_GE:     COND_TRUE = ~(w_s ^ w_v);
            C_GT:     COND_TRUE = ~w_z & ~(w_s ^ w_v);
            C_LE:     COND_TRUE = w_z | (w_s ^ w_v);
            C_HI:     COND_TRUE = ~w_c & ~w_z;
            C_LS:     COND_TRUE = w_c | w_z;
            C_NEVER:  COND_TRUE = 1'b0;
            default:  COND_TRUE = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback. A queue scoreboard predicts the FIFO and flags,
// and every cycle is checked against that prediction.
module tb_alu_writeback;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] ALU_RESULT;
    logic [3:0]  FLAG_IN;
    logic [2:0]  RD_ADDR;
    logic        WE_REG;
    logic        WE_FLAG;
    logic [3:0]  COND;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] WB_DATA;
    logic [2:0]  WB_ADDR;
    logic        WB_WE;
    logic [3:0]  FLAG_REG;
    logic        COND_TRUE;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  addr;
        logic        we;
    } exp_entry_t;

    exp_entry_t  sb[$];
    logic [3:0]  exp_flags;
    int          n_checks = 0;
    int          n_fail   = 0;

    alu_writeback dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALU_RESULT(ALU_RESULT),
        .FLAG_IN   (FLAG_IN),
        .RD_ADDR   (RD_ADDR),
        .WE_REG    (WE_REG),
        .WE_FLAG   (WE_FLAG),
        .COND      (COND),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .WB_DATA   (WB_DATA),
        .WB_ADDR   (WB_ADDR),
        .WB_WE     (WB_WE),
        .FLAG_REG  (FLAG_REG),
        .COND_TRUE (COND_TRUE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model, then advance one clock while updating it.
    task automatic tick();
        logic can_push;
        #1;
        check("in_ready",  IN_READY,  sb.size() < 2);
        check("out_valid", OUT_VALID, sb.size() != 0);
        check("flag_reg",  FLAG_REG,  exp_flags);
        if (sb.size() != 0) begin
            check("wb_data", WB_DATA, sb[0].data);
            check("wb_addr", WB_ADDR, sb[0].addr);
            check("wb_we",   WB_WE,   sb[0].we);
        end else begin
            check("wb_data_idle", WB_DATA, 16'h0000);
            check("wb_addr_idle", WB_ADDR, 3'd0);
            check("wb_we_idle",   WB_WE,   1'b0);
        end
        can_push = (sb.size() < 2);
        if (OUT_READY && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (IN_VALID && can_push) begin
            sb.push_back('{data: ALU_RESULT, addr: RD_ADDR, we: WE_REG});
            if (WE_FLAG) exp_flags = FLAG_IN;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] a,
                         input logic we, input logic wf, input logic [3:0] f);
        IN_VALID   = v;
        ALU_RESULT = d;
        RD_ADDR    = a;
        WE_REG     = we;
        WE_FLAG    = wf;
        FLAG_IN    = f;
    endtask

    initial begin
        logic [15:0] cond_mask;
        RST = 1'b1;
        OUT_READY = 1'b0;
        COND = 4'd0;
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0);
        exp_flags = 4'b0000;

        // Outputs under reset before any clock edge
        #1;
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_in_ready",  IN_READY,  1'b1);
        check("rst_flag_reg",  FLAG_REG,  4'b0000);
        check("rst_wb_data",   WB_DATA,   16'h0000);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Single entry into empty FIFO, flags committed on push
        OUT_READY = 1'b1;
        drive(1'b1, 16'h1234, 3'd3, 1'b1, 1'b1, 4'b0010);
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0);
        check("one_cycle_latency", OUT_VALID, 1'b1);
        check("first_data", WB_DATA, 16'h1234);
        tick();
        tick();

        // Fill while stalled, hold a third push off, then drain in order
        OUT_READY = 1'b0;
        drive(1'b1, 16'h0001, 3'd1, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b1, 16'h0002, 3'd2, 1'b1, 1'b0, 4'h0);
        tick();
        check("full_in_ready", IN_READY, 1'b0);
        drive(1'b1, 16'h0003, 3'd5, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) tick();
        OUT_READY = 1'b1;
        tick();
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0);
        check("third_accepted", WB_DATA, 16'h0003);
        tick();
        tick();

        // Simultaneous push and pop at count 1 keeps order
        OUT_READY = 1'b0;
        drive(1'b1, 16'hAAAA, 3'd6, 1'b1, 1'b0, 4'h0);
        tick();
        OUT_READY = 1'b1;
        drive(1'b1, 16'hBBBB, 3'd7, 1'b1, 1'b0, 4'h0);
        tick();
        OUT_READY = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0);
        check("pushpop_head", WB_DATA, 16'hBBBB);
        tick();
        OUT_READY = 1'b1;
        tick();

        // Flag hold when WE_FLAG=0; WE_REG=0 entries still pass through
        drive(1'b1, 16'h5555, 3'd4, 1'b0, 1'b1, 4'b0100);
        tick();
        drive(1'b1, 16'h6666, 3'd2, 1'b0, 1'b0, 4'b1001);
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0);
        check("flag_hold", FLAG_REG, 4'b0100);
        COND = 4'd1;
        #1 check("cond_eq_z", COND_TRUE, 1'b1);
        COND = 4'd2;
        #1 check("cond_ne_z", COND_TRUE, 1'b0);
        tick();
        tick();

        // Full condition sweep on S=1, Z=C=V=0
        drive(1'b1, 16'h7777, 3'd0, 1'b1, 1'b1, 4'b1000);
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0);
        tick();
        cond_mask = 16'h334D;
        for (int c = 0; c < 16; c++) begin
            COND = c[3:0];
            #1 check($sformatf("cond_sweep_%0d", c), COND_TRUE, cond_mask[c]);
        end

        // Asynchronous reset with a full FIFO and all flags set
        OUT_READY = 1'b0;
        drive(1'b1, 16'h1111, 3'd1, 1'b1, 1'b1, 4'b1111);
        tick();
        drive(1'b1, 16'h2222, 3'd2, 1'b1, 1'b1, 4'b1111);
        tick();
        check("pre_rst_flags", FLAG_REG, 4'b1111);
        #2 RST = 1'b1;
        #1;
        sb.delete();
        exp_flags = 4'b0000;
        check("arst_out_valid", OUT_VALID, 1'b0);
        check("arst_wb_data",   WB_DATA,   16'h0000);
        check("arst_wb_we",     WB_WE,     1'b0);
        check("arst_flags",     FLAG_REG,  4'b0000);
        check("arst_in_ready",  IN_READY,  1'b1);
        OUT_READY = 1'b1;
        drive(1'b1, 16'hDEAD, 3'd3, 1'b1, 1'b1, 4'b0101);
        @(posedge CLK);
        @(negedge CLK);
        check("rst_handshake_ignored", OUT_VALID, 1'b0);
        RST = 1'b0;
        OUT_READY = 1'b0;
        drive(1'b1, 16'h00FF, 3'd2, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0);
        check("post_rst_data", WB_DATA, 16'h00FF);
        OUT_READY = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have no parameters; data width fixed 16, register address width fixed 3, queue depth fixed 2.
REQ-002 SHALL have port CLK  input  1  the one clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port IN_VALID  input  1  upstream ALU result valid.
REQ-005 SHALL have port IN_READY  output  1  block can accept an entry this cycle.
REQ-006 SHALL have port ALU_RESULT  input  16  ALU_OUT from the 16-bit ALU.
REQ-007 SHALL have port FLAG_IN  input  4  ALU FLAG_OUT, ordered {S, Z, C, V}.
REQ-008 SHALL have port RD_ADDR  input  3  destination register index.
REQ-009 SHALL have port WE_REG  input  1  entry writes the register file.
REQ-010 SHALL have port WE_FLAG  input  1  entry updates the flag register.
REQ-011 SHALL have port COND  input  4  branch-condition selector.
REQ-012 SHALL have port OUT_VALID  output  1  head entry present.
REQ-013 SHALL have port OUT_READY  input  1  register file accepts head entry.
REQ-014 SHALL have port WB_DATA  output  16  head entry result.
REQ-015 SHALL have port WB_ADDR  output  3  head entry destination.
REQ-016 SHALL have port WB_WE  output  1  OUT_VALID AND head entry WE_REG.
REQ-017 SHALL have port FLAG_REG  output  4  committed flags {S, Z, C, V}.
REQ-018 SHALL have port COND_TRUE  output  1  COND evaluated on FLAG_REG.

Function
REQ-019 SHALL hold a 2-entry FIFO of {data, addr, we} with 2-bit count 0..2.
REQ-020 SHALL drive IN_READY = (count != 2); IN_READY SHALL NOT depend combinationally on OUT_READY or IN_VALID.
REQ-021 SHALL push on IN_VALID & IN_READY; pop on OUT_VALID & OUT_READY; OUT_VALID = (count != 0).
REQ-022 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order (count 1: new entry becomes head next cycle; count 2: not reachable since IN_READY=0).
REQ-023 SHALL give push-to-OUT_VALID latency of exactly 1 cycle when empty; no bypass path from inputs to WB_* outputs.
REQ-024 SHALL keep WB_DATA/WB_ADDR stable while OUT_VALID & !OUT_READY; WB_* SHALL be 0 when count = 0.
REQ-025 SHALL ignore pop attempts when empty and push attempts when full (no state change, no entry loss).
REQ-026 SHALL pass entries with WE_REG=0 through the FIFO in order (WB_WE=0 on their pop cycle).
REQ-027 SHALL load FLAG_REG <= FLAG_IN on the push edge when WE_FLAG=1; otherwise FLAG_REG holds; flag commit SHALL NOT wait for pop.
REQ-028 SHALL compute COND_TRUE combinationally from registered FLAG_REG (new flags visible the cycle after push): 0 always; 1 Z; 2 !Z; 3 S; 4 !S; 5 C; 6 !C; 7 V; 8 !V; 9 S^V (signed lt); 10 !(S^V) (signed ge); 11 !Z & !(S^V) (signed gt); 12 Z | (S^V) (signed le); 13 !C & !Z (unsigned gt); 14 C | Z (unsigned le); 15 never.
REQ-029 SHALL treat C as borrow for subtraction results (C=1 means A<B unsigned), consistent with the ALU's 17-bit result bit 16.

Reset
REQ-030 SHALL, while RST=1 regardless of CLK, force count=0, FLAG_REG=4'b0000, OUT_VALID=0, WB_DATA=0, WB_ADDR=0, WB_WE=0, IN_READY=1.
REQ-031 SHALL discard all queued entries when RST asserts mid-operation; a handshake in the reset cycle SHALL have no effect.
REQ-032 SHALL resume normal operation on the first rising CLK edge after RST deasserts.

Verification
REQ-033 Push {0x1234, addr 3, WE_REG=1, WE_FLAG=1, FLAG_IN=4'b0010} into empty, OUT_READY=1 -> next cycle OUT_VALID=1, WB_DATA=0x1234, WB_ADDR=3, WB_WE=1, FLAG_REG=4'b0010; popped following edge, count 0.
REQ-034 OUT_READY=0, push 0x0001 then 0x0002 -> IN_READY=0 after 2nd push, third IN_VALID held 3 cycles not accepted; OUT_READY=1 -> pops 0x0001, 0x0002 in order, then third entry accepted.
REQ-035 Count=1 head 0xAAAA, simultaneous push 0xBBBB and pop -> count stays 1, next WB_DATA=0xBBBB.
REQ-036 FLAG_REG=4'b0100 then push with WE_FLAG=0, FLAG_IN=4'b1001 -> FLAG_REG stays 4'b0100; COND=1 -> COND_TRUE=1, COND=2 -> 0.
REQ-037 Sweep COND 0..15 for FLAG_REG=4'b1000 (S=1,V=0) -> COND_TRUE=1 for COND 0,2,3,6,8,9,12,13; 0 otherwise.
REQ-038 With count=2, FLAG_REG=4'b1111, assert RST asynchronously mid-cycle -> outputs zero immediately, FLAG_REG=0, IN_READY=1; after release, push 0x00FF appears at WB_DATA one cycle later.
